// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// the legal data-memory word window and requester identifiers.
package dmem_pkg;

    // Legal data-memory word window (byte addresses 0x1000..0x1FFC)
    localparam int unsigned DMEM_WORD_LO = 1024;
    localparam int unsigned DMEM_WORD_HI = 2047;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant.
// Ports:
//   valid      - request valids, bit 0 = m0, bit 1 = m1
//   last_grant - id of the requester granted most recently
//   grant      - one-hot grant (all zero when nothing is valid)
module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // On a tie the requester that was not granted last wins
    always_comb begin
        grant = 2'b00;
        if (valid[0] && (!valid[1] || (last_grant == REQ_M1))) begin
            grant = 2'b01;
        end else if (valid[1]) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of the data memory.
// One transaction every three cycles: IDLE (accept) -> ACCESS -> RESP.
// Ports:
//   clk, reset_n                  - clock, synchronous active-low reset
//   m{0,1}_req_{valid,ready,we,addr,wdata} - request handshake and payload
//   m{0,1}_rsp_{valid,rdata,err}  - one-cycle response pulse
//   mem_{wr_en,addr,din}          - memory write-enable, address, write data
//   mem_dout                      - memory read data, one cycle after address
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORD_LO    = DMEM_WORD_LO,
    parameter int unsigned WORD_HI    = DMEM_WORD_HI
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  m0_req_valid,
    output logic                  m0_req_ready,
    input  logic                  m0_req_we,
    input  logic [ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [DATA_WIDTH-1:0] m0_req_wdata,
    output logic                  m0_rsp_valid,
    output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
    output logic                  m0_rsp_err,

    input  logic                  m1_req_valid,
    output logic                  m1_req_ready,
    input  logic                  m1_req_we,
    input  logic [ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [DATA_WIDTH-1:0] m1_req_wdata,
    output logic                  m1_rsp_valid,
    output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
    output logic                  m1_rsp_err,

    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int unsigned WORD_W = ADDR_WIDTH - 2;

    state_t                  state_q, state_d;
    logic                    last_grant_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    id_q;
    logic                    err_q;

    logic [1:0]              grant;
    logic                    accept;
    logic                    sel_id;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [WORD_W-1:0]       sel_word;
    logic                    sel_err;

    // Grant only in IDLE and never while reset is asserted
    rr_arb2 u_rr_arb2 (
        .valid      ({m1_req_valid, m0_req_valid} & {2{reset_n && (state_q == ST_IDLE)}}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    assign accept    = |grant;
    assign sel_id    = grant[1] ? REQ_M1 : REQ_M0;
    assign sel_we    = grant[1] ? m1_req_we    : m0_req_we;
    assign sel_addr  = grant[1] ? m1_req_addr  : m0_req_addr;
    assign sel_wdata = grant[1] ? m1_req_wdata : m0_req_wdata;

    // Misaligned or outside the data-memory word window
    assign sel_word = sel_addr[ADDR_WIDTH-1:2];
    assign sel_err  = (sel_addr[1:0] != 2'b00)
                   || (sel_word < WORD_W'(WORD_LO))
                   || (sel_word > WORD_W'(WORD_HI));

    // State and captured-request registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ_M1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            id_q         <= REQ_M0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= sel_id;
                we_q         <= sel_we;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                id_q         <= sel_id;
                err_q        <= sel_err;
            end
        end
    end

    // Next state and outputs
    always_comb begin
        state_d      = state_q;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m0_rsp_rdata = '0;
        m0_rsp_err   = 1'b0;
        m1_rsp_valid = 1'b0;
        m1_rsp_rdata = '0;
        m1_rsp_err   = 1'b0;
        mem_wr_en    = 1'b0;
        mem_addr     = '0;
        mem_din      = '0;

        case (state_q)
            ST_IDLE: begin
                m0_req_ready = grant[0];
                m1_req_ready = grant[1];
                if (accept) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // reset_n gate: a reset landing here must not write
                mem_wr_en = we_q && !err_q && reset_n;
                mem_addr  = err_q ? '0 : addr_q;
                mem_din   = wdata_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                if (id_q == REQ_M1) begin
                    m1_rsp_valid = 1'b1;
                    m1_rsp_rdata = (!we_q && !err_q) ? mem_dout : '0;
                    m1_rsp_err   = err_q;
                end else begin
                    m0_rsp_valid = 1'b1;
                    m0_rsp_rdata = (!we_q && !err_q) ? mem_dout : '0;
                    m0_rsp_err   = err_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic        m0_rsp_valid, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [31:0] m1_req_addr, m1_req_wdata;
    logic        m1_rsp_valid, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_din;
    logic [31:0] mem_dout = 32'h0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem [0:4095];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_req_valid (m0_req_valid),
        .m0_req_ready (m0_req_ready),
        .m0_req_we    (m0_req_we),
        .m0_req_addr  (m0_req_addr),
        .m0_req_wdata (m0_req_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m0_rsp_err   (m0_rsp_err),
        .m1_req_valid (m1_req_valid),
        .m1_req_ready (m1_req_ready),
        .m1_req_we    (m1_req_we),
        .m1_req_addr  (m1_req_addr),
        .m1_req_wdata (m1_req_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_rdata (m1_rsp_rdata),
        .m1_rsp_err   (m1_rsp_err),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    // Data memory: synchronous write, registered read
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr[13:2]] <= mem_din;
        mem_dout <= mem[mem_addr[13:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            m0_req_valid = v; m0_req_we = we; m0_req_addr = addr; m0_req_wdata = wdata;
        end else begin
            m1_req_valid = v; m1_req_we = we; m1_req_addr = addr; m1_req_wdata = wdata;
        end
    endtask

    // Full transaction on one port; called and returns just after a negedge in IDLE
    task automatic txn(input int p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input string tag);
        int waited = 0;
        set_req(p, 1'b1, we, addr, wdata);
        #1;
        while (((p == 0) ? m0_req_ready : m1_req_ready) !== 1'b1 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        check({tag, "_ready"},  (p == 0) ? m0_req_ready : m1_req_ready, 32'd1);
        check({tag, "_oready"}, (p == 0) ? m1_req_ready : m0_req_ready, 32'd0);
        @(negedge clk);
        set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check({tag, "_wr_en"},  mem_wr_en, 32'(we && !exp_err));
        check({tag, "_maddr"},  mem_addr, exp_err ? 32'h0 : addr);
        @(negedge clk); #1;
        check({tag, "_rvalid"}, (p == 0) ? m0_rsp_valid : m1_rsp_valid, 32'd1);
        check({tag, "_orvalid"}, (p == 0) ? m1_rsp_valid : m0_rsp_valid, 32'd0);
        check({tag, "_rdata"},  (p == 0) ? m0_rsp_rdata : m1_rsp_rdata, exp_rdata);
        check({tag, "_err"},    (p == 0) ? m0_rsp_err : m1_rsp_err, 32'(exp_err));
        check({tag, "_wr_en_resp"}, mem_wr_en, 32'd0);
        @(negedge clk);
    endtask

    // Both ports hold a read request; grants must alternate starting at 'first'
    task automatic tie_run(input int n, input int first,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] d0, input logic [31:0] d1, input string tag);
        int w = first;
        set_req(0, 1'b1, 1'b0, a0, 32'h0);
        set_req(1, 1'b1, 1'b0, a1, 32'h0);
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, "_rdy0"}, m0_req_ready, 32'(w == 0));
            check({tag, "_rdy1"}, m1_req_ready, 32'(w == 1));
            @(negedge clk); #1;
            check({tag, "_acc_rdy"}, {m1_req_ready, m0_req_ready}, 32'd0);
            check({tag, "_maddr"}, mem_addr, (w == 0) ? a0 : a1);
            @(negedge clk); #1;
            check({tag, "_rsp_rdy"}, {m1_req_ready, m0_req_ready}, 32'd0);
            check({tag, "_rv0"}, m0_rsp_valid, 32'(w == 0));
            check({tag, "_rv1"}, m1_rsp_valid, 32'(w == 1));
            check({tag, "_rdata"}, (w == 0) ? m0_rsp_rdata : m1_rsp_rdata, (w == 0) ? d0 : d1);
            @(negedge clk);
            w = 1 - w;
        end
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[1025] = 32'h1111_1111;
        mem[1026] = 32'h2222_2222;
        mem[2047] = 32'h7777_7777;
        set_req(0, 1'b1, 1'b1, 32'h1000, 32'h5555_5555);
        set_req(1, 1'b1, 1'b1, 32'h1004, 32'h6666_6666);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        // Outputs stay quiet while reset is held, even with requests pending
        check("rst_ready", {m1_req_ready, m0_req_ready}, 32'd0);
        check("rst_wr_en", mem_wr_en, 32'd0);
        check("rst_maddr", mem_addr, 32'd0);
        check("rst_rsp",   {m1_rsp_valid, m0_rsp_valid, m1_rsp_err, m0_rsp_err}, 32'd0);
        check("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'd0);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // m0 write then read back
        txn(0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 32'h0, 1'b0, "m0_wr");
        check("m0_wr_mem", mem[1024], 32'hDEAD_BEEF);
        txn(0, 1'b0, 32'h1000, 32'h0, 32'hDEAD_BEEF, 1'b0, "m0_rd");

        // Simultaneous requests straight out of reset
        do_reset();
        @(negedge clk);
        tie_run(4, 0, 32'h1004, 32'h1008, 32'h1111_1111, 32'h2222_2222, "tie");

        // Out-of-range writes from m1, then a read of the top word
        txn(1, 1'b1, 32'h0000_0FFC, 32'h0BAD_0BAD, 32'h0, 1'b1, "oor_lo");
        txn(1, 1'b1, 32'h0000_2000, 32'h0BAD_0BAD, 32'h0, 1'b1, "oor_hi");
        check("oor_lo_mem", mem[1023], 32'h0);
        check("oor_hi_mem", mem[2048], 32'h0);
        txn(1, 1'b0, 32'h1FFC, 32'h0, 32'h7777_7777, 1'b0, "top_rd");

        // Misaligned read and misaligned write
        txn(0, 1'b0, 32'h1002, 32'h0, 32'h0, 1'b1, "mis_rd");
        txn(0, 1'b1, 32'h1006, 32'h1234_5678, 32'h0, 1'b1, "mis_wr");
        check("mis_wr_mem", mem[1025], 32'h1111_1111);

        // Reset landing in the ACCESS cycle of an m0 write
        set_req(0, 1'b1, 1'b1, 32'h1010, 32'hCAFE_F00D);
        #1;
        check("rst_acc_ready", m0_req_ready, 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        check("rst_acc_wr_en", mem_wr_en, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_acc_rv", {m1_rsp_valid, m0_rsp_valid}, 32'd0);
        @(negedge clk); #1;
        check("rst_acc_rv2", {m1_rsp_valid, m0_rsp_valid}, 32'd0);
        check("rst_acc_mem", mem[1028], 32'h0);
        @(negedge clk);
        tie_run(2, 0, 32'h1010, 32'h1008, 32'h0, 32'h2222_2222, "post_rst");

        // m1 holds a write while m0 is being served
        set_req(0, 1'b1, 1'b1, 32'h1020, 32'h1234_5678);
        #1;
        check("hold_m0_ready", m0_req_ready, 32'd1);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b1, 1'b1, 32'h1024, 32'hA5A5_A5A5);
        #1;
        check("hold_acc_m1rdy", m1_req_ready, 32'd0);
        @(negedge clk); #1;
        check("hold_rsp_m1rdy", m1_req_ready, 32'd0);
        check("hold_rsp_m0rv", m0_rsp_valid, 32'd1);
        @(negedge clk); #1;
        check("hold_idle_m1rdy", m1_req_ready, 32'd1);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("hold_wr_en", mem_wr_en, 32'd1);
        check("hold_maddr", mem_addr, 32'h1024);
        check("hold_mdin",  mem_din, 32'hA5A5_A5A5);
        @(negedge clk); #1;
        check("hold_m1rv", m1_rsp_valid, 32'd1);
        check("hold_m1err", m1_rsp_err, 32'd0);
        @(negedge clk);
        check("hold_mem_m0", mem[1032], 32'h1234_5678);
        check("hold_mem_m1", mem[1033], 32'hA5A5_A5A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
